// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder.
// Holds the access-size encodings, the FSM state type and the captured
// request-control payload.
package dmem_responder_pkg;

  // Access size encodings on req_size
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  // Wait counter width, sized for LATENCY 0..15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Control fields latched on accept
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
  } req_ctl_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory.
// Ports:
//   size, offset, is_unsigned : access size, addr[1:0], load extension mode
//   wdata                     : right-aligned store data
//   rword                     : full memory word being read
//   be_c                      : per-byte write enables
//   wrep_c                    : store data replicated across the lanes
//   rext_c                    : selected load lane(s), sign/zero extended
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rword,
  output logic [XLEN/8-1:0] be_c,
  output logic [XLEN-1:0]   wrep_c,
  output logic [XLEN-1:0]   rext_c
);

  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] shifted;

  // Move the addressed lane down to bit 0
  assign shifted = rword >> {offset, 3'b000};

  always_comb begin
    be_c   = '0;
    wrep_c = '0;
    rext_c = '0;
    case (size)
      MEM_B: begin
        be_c   = NB'(1) << offset;
        wrep_c = {(XLEN/8){wdata[7:0]}};
        rext_c = is_unsigned ? XLEN'(shifted[7:0])
                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be_c   = NB'(3) << offset;
        wrep_c = {(XLEN/16){wdata[15:0]}};
        rext_c = is_unsigned ? XLEN'(shifted[15:0])
                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        be_c   = NB'(4'hF) << offset;
        wrep_c = {(XLEN/32){wdata[31:0]}};
        rext_c = shifted;
      end
      default: begin
        be_c   = '0;
        wrep_c = '0;
        rext_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   req_valid/req_ready               : request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata           : request payload
//   rsp_valid/rsp_ready               : response handshake
//   rsp_rdata, rsp_err                : load result / error flag
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  req_ctl_t         ctl;
  logic [XLEN-1:0]  addr_q, wdata_q;
  logic [XLEN-1:0]  mem [DEPTH_WORDS];

  logic             accept_c, access_c, err_c, mem_we_c;
  logic [AW-1:0]    idx_c;
  logic [XLEN-1:0]  rword_c, wrep_c, rext_c;
  logic [NB-1:0]    be_c;

  logic             rsp_valid_n, rsp_err_n, req_ready_n;
  logic [XLEN-1:0]  rsp_rdata_n;

  assign accept_c = req_valid && req_ready;
  // Access happens on the WAIT cycle where the counter has run out
  assign access_c = (state == ST_WAIT) && (cnt == '0);
  assign idx_c    = addr_q[AW+1:2];
  assign rword_c  = mem[idx_c];
  assign mem_we_c = access_c && ctl.we && !err_c;

  // Alignment, illegal-size and range checks on the captured request
  always_comb begin
    err_c = 1'b0;
    case (ctl.size)
      MEM_B:   err_c = 1'b0;
      MEM_H:   err_c = addr_q[0];
      MEM_W:   err_c = |addr_q[1:0];
      default: err_c = 1'b1;
    endcase
    if ((addr_q >> 2) >= XLEN'(DEPTH_WORDS)) err_c = 1'b1;
  end

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .size        (ctl.size),
    .offset      (addr_q[1:0]),
    .is_unsigned (ctl.is_unsigned),
    .wdata       (wdata_q),
    .rword       (rword_c),
    .be_c        (be_c),
    .wrep_c      (wrep_c),
    .rext_c      (rext_c)
  );

  // Memory: one synchronous write port with byte enables, never reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < NB; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wrep_c[8*i +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept_c)               state_n = ST_WAIT;
      ST_WAIT: if (cnt == '0)              state_n = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_n = ST_IDLE;
      default:                             state_n = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    req_ready_n = (state_n == ST_IDLE);
    if (access_c) begin
      rsp_valid_n = 1'b1;
      rsp_err_n   = err_c;
      rsp_rdata_n = (ctl.we || err_c) ? '0 : rext_c;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid_n = 1'b0;
      rsp_rdata_n = '0;
      rsp_err_n   = 1'b0;
    end
  end

  // Request capture and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ctl     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept_c) begin
        cnt     <= CNT_W'(LATENCY);
        ctl     <= '{we: req_we, size: req_size, is_unsigned: req_unsigned};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      req_ready <= req_ready_n;
    end
  end

endmodule
